lzc_arbiter: RTL and testbench

LZC_ARBITER -- requirements
Module: lzc_arbiter

---
 rtl/lzc_arbiter.sv | 179 +++++++++++++++++
 tb/tb_lzc_arbiter.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/lzc_arbiter.sv
// lzc_arbiter: two-requester round-robin front end for a sliced
// leading-zero-count engine. A granted operand is streamed to the engine
// MSB slice first, and the engine's count is returned as a one-cycle response.
// Optional feature: define LZC_ARB_TIMEOUT_EN to give up on a silent engine
// after TIMEOUT cycles in WAIT and answer with zeros=W, err=1.
module lzc_arbiter #(
   parameter int width   = 8,
   parameter int word    = 4,
   parameter int TIMEOUT = 16,
   localparam int W  = width * word,
   localparam int ZW = $clog2(W) + 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          req0,
   input  logic          req1,
   input  logic [W-1:0]  op0,
   input  logic [W-1:0]  op1,
   input  logic          mode0,
   input  logic          mode1,
   output logic          ack0,
   output logic          ack1,
   output logic          rsp_valid,
   output logic          rsp_id,
   output logic [ZW-1:0] rsp_zeros,
   output logic          rsp_err,
   output logic [width-1:0] eng_data,
   output logic          eng_ivalid,
   output logic          eng_mode,
   input  logic [ZW-1:0] eng_zeros,
   input  logic          eng_ovalid
);

   localparam int CW = $clog2(word + 1);

   generate
      if (width < 1 || word < 1 || TIMEOUT < 1) begin : g_bad_param
         $error("lzc_arbiter: width, word and TIMEOUT must all be >= 1");
      end
   endgenerate

   typedef enum logic [1:0] {IDLE, FEED, WAIT, RESP} state_t;

   typedef struct packed {
      logic id;
      logic mode;
   } req_t;

   state_t          state_q, state_d;
   logic [W-1:0]    buf_q;      // shifts left one slice per FEED cycle
   req_t            req_q;
   logic            pref_q;     // requester that wins a tie next
   logic [CW-1:0]   slice_q;
   logic            grant_en, grant_id;
   logic            cap_en;     // engine result accepted this cycle
   logic            tmo_fire;
   logic [ZW-1:0]   zeros_sat;

`ifdef LZC_ARB_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT + 1);
   logic [TW-1:0]   tmo_q;
   logic            err_q;
`endif

   // Arbitration: a new grant can be issued from IDLE or from the RESP
   // cycle so back-to-back operations do not lose a cycle.
   always_comb begin
      grant_en = (state_q == IDLE || state_q == RESP) && (req0 || req1);
      grant_id = (req0 && req1) ? pref_q : req1;
   end

   // Engine counts above the operand width are clamped to W.
   always_comb begin
      zeros_sat = (eng_zeros > ZW'(W)) ? ZW'(W) : eng_zeros;
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Next-state logic; engine result capture and timeout decisions.
   always_comb begin
      state_d  = state_q;
      cap_en   = 1'b0;
      tmo_fire = 1'b0;
      case (state_q)
         IDLE: if (grant_en) state_d = FEED;
         FEED: begin
            if (eng_ovalid) begin
               cap_en  = 1'b1;
               state_d = RESP;
            end else if (slice_q == CW'(word - 1)) begin
               state_d = WAIT;
            end
         end
         WAIT: begin
            if (eng_ovalid) begin
               cap_en  = 1'b1;
               state_d = RESP;
            end
`ifdef LZC_ARB_TIMEOUT_EN
            else if (tmo_q == TW'(TIMEOUT - 1)) begin
               tmo_fire = 1'b1;
               state_d  = RESP;
            end
`endif
         end
         RESP: state_d = grant_en ? FEED : IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Grant bookkeeping, ack pulses and operand slicing.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ack0    <= 1'b0;
         ack1    <= 1'b0;
         buf_q   <= '0;
         req_q   <= '0;
         pref_q  <= 1'b0;
         slice_q <= '0;
      end else begin
         ack0 <= grant_en && !grant_id;
         ack1 <= grant_en &&  grant_id;
         if (grant_en) begin
            buf_q      <= grant_id ? op1 : op0;
            req_q.mode <= grant_id ? mode1 : mode0;
            req_q.id   <= grant_id;
            pref_q     <= ~grant_id;
            slice_q    <= '0;
         end else if (state_q == FEED) begin
            buf_q   <= buf_q << width;
            slice_q <= slice_q + 1'b1;
         end
      end
   end

   // Response registers, loaded when the engine answers or times out.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_id    <= 1'b0;
         rsp_zeros <= '0;
      end else if (cap_en) begin
         rsp_id    <= req_q.id;
         rsp_zeros <= zeros_sat;
      end else if (tmo_fire) begin
         rsp_id    <= req_q.id;
         rsp_zeros <= ZW'(W);
      end
   end

`ifdef LZC_ARB_TIMEOUT_EN
   // Timeout counter runs only while waiting; error flag follows the response.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tmo_q <= '0;
         err_q <= 1'b0;
      end else begin
         tmo_q <= (state_q == WAIT) ? tmo_q + 1'b1 : '0;
         if (cap_en)        err_q <= 1'b0;
         else if (tmo_fire) err_q <= 1'b1;
      end
   end
   assign rsp_err = err_q;
`else
   assign rsp_err = 1'b0;
`endif

   // Outputs decoded from state so reset clears them immediately.
   always_comb begin
      rsp_valid  = (state_q == RESP);
      eng_ivalid = (state_q == FEED);
      eng_data   = (state_q == FEED) ? buf_q[W-1 -: width] : '0;
      eng_mode   = (state_q != IDLE) ? req_q.mode : 1'b0;
   end

endmodule

// File: tb/tb_lzc_arbiter.sv
// Directed bench for lzc_arbiter (default parameters, W=32). Expected
// responses go into a scoreboard queue when a request is issued and are
// popped by a monitor whenever rsp_valid is seen.
module tb_lzc_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req0, req1, mode0, mode1;
   logic [31:0] op0, op1;
   logic        ack0, ack1, rsp_valid, rsp_id, rsp_err;
   logic [5:0]  rsp_zeros, eng_zeros;
   logic [7:0]  eng_data;
   logic        eng_ivalid, eng_mode, eng_ovalid;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic       id;
      logic [5:0] zeros;
      logic       err;
   } exp_t;
   exp_t sb[$];

   lzc_arbiter dut (
      .clk(clk), .rst_n(rst_n),
      .req0(req0), .req1(req1), .op0(op0), .op1(op1),
      .mode0(mode0), .mode1(mode1), .ack0(ack0), .ack1(ack1),
      .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_zeros(rsp_zeros),
      .rsp_err(rsp_err), .eng_data(eng_data), .eng_ivalid(eng_ivalid),
      .eng_mode(eng_mode), .eng_zeros(eng_zeros), .eng_ovalid(eng_ovalid)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [5:0] sat(input int z);
      return (z > 32) ? 6'd32 : 6'(z);
   endfunction

   task automatic push(input logic id, input logic [5:0] z, input logic err);
      exp_t e;
      e.id = id; e.zeros = z; e.err = err;
      sb.push_back(e);
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_ack0"}, ack0, 0);
      chk({tag, "_ack1"}, ack1, 0);
      chk({tag, "_rsp_valid"}, rsp_valid, 0);
      chk({tag, "_rsp_id"}, rsp_id, 0);
      chk({tag, "_rsp_zeros"}, rsp_zeros, 0);
      chk({tag, "_rsp_err"}, rsp_err, 0);
      chk({tag, "_eng_ivalid"}, eng_ivalid, 0);
      chk({tag, "_eng_data"}, eng_data, 0);
      chk({tag, "_eng_mode"}, eng_mode, 0);
   endtask

   // Wait (bounded) for the ack of requester id, then drop its request.
   task automatic wait_ack(input int id, output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!((id != 0) ? ack1 : ack0) && n < 8);
      chk("ack_seen", (id != 0) ? ack1 : ack0, 1);
      chk("ack_other", (id != 0) ? ack0 : ack1, 0);
      if (id != 0) req1 = 1'b0;
      else         req0 = 1'b0;
   endtask

   // Starts in the slice-0 cycle. ovs>=0: engine answers during that slice;
   // ovs=-1: engine answers in the first WAIT cycle; ovs=-2: never answers,
   // return in the first WAIT cycle.
   task automatic feed(input logic [31:0] op, input logic mode, input int ovs,
                       input logic [5:0] zr);
      logic [31:0] sh;
      for (int k = 0; k < 4; k++) begin
         sh = op >> (8 * (3 - k));
         chk("slice_ivalid", eng_ivalid, 1);
         chk("slice_data", eng_data, sh[7:0]);
         chk("slice_mode", eng_mode, mode);
         if (k == 1) chk("ack_one_pulse", {ack0, ack1}, 0);
         if (k == ovs) begin
            eng_ovalid = 1'b1;
            eng_zeros  = zr;
         end
         @(negedge clk);
         eng_ovalid = 1'b0;
         if (k == ovs) break;
      end
      if (ovs < 0) begin
         chk("wait_ivalid", eng_ivalid, 0);
         chk("wait_data", eng_data, 0);
         chk("wait_mode", eng_mode, mode);
         if (ovs == -2) return;
         eng_ovalid = 1'b1;
         eng_zeros  = zr;
         @(negedge clk);
         eng_ovalid = 1'b0;
      end
      chk("rsp_latency", rsp_valid, 1);
      chk("rsp_ivalid", eng_ivalid, 0);
      chk("rsp_mode", eng_mode, mode);
   endtask

   // Scoreboard monitor: every response must match the oldest expectation.
   always @(negedge clk) begin
      if (rst_n && rsp_valid) begin
         if (sb.size() == 0) begin
            chk("rsp_unexpected", rsp_valid, 0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("rsp_id", rsp_id, e.id);
            chk("rsp_zeros", rsp_zeros, e.zeros);
            chk("rsp_err", rsp_err, e.err);
         end
      end
   end

   initial begin
      int n;
      rst_n = 1'b0; req0 = 0; req1 = 0; mode0 = 0; mode1 = 0;
      op0 = '0; op1 = '0; eng_ovalid = 0; eng_zeros = '0;
      #12;
      check_all_zero("reset");
      @(negedge clk); rst_n = 1'b1;
      @(negedge clk);

      // Simultaneous requests after reset: 0 first, 1 right after RESP.
      req0 = 1; op0 = 32'h0000_1000; mode0 = 0;
      req1 = 1; op1 = 32'h0F00_0000; mode1 = 0;
      push(0, sat(19), 0);
      push(1, sat(4), 0);
      wait_ack(0, n);
      feed(32'h0000_1000, 0, -1, 6'd19);
      chk("pending_no_ack1", ack1, 0);
      // Next simultaneous pair issued in the RESP cycle: 0 wins again.
      wait_ack(1, n);
      chk("b2b_gap", n, 1);
      feed(32'h0F00_0000, 0, -1, 6'd4);
      req0 = 1; op0 = 32'h8000_0000; mode0 = 0;
      req1 = 1; op1 = 32'h0000_0000; mode1 = 0;
      push(0, sat(0), 0);
      push(1, sat(32), 0);
      wait_ack(0, n);
      chk("b2b_gap_rr", n, 1);
      feed(32'h8000_0000, 0, -1, 6'd0);
      wait_ack(1, n);
      feed(32'h0000_0000, 0, -1, 6'd32);
      @(negedge clk);
      chk("idle_after_rsp", rsp_valid, 0);

      // Engine output while idle must be ignored.
      eng_ovalid = 1; eng_zeros = 6'd7;
      @(negedge clk);
      eng_ovalid = 0;
      @(negedge clk);
      chk("idle_ovalid_ignored", rsp_valid, 0);
      chk("idle_ovalid_ivalid", eng_ivalid, 0);

      // Reset during slice 2 abandons the operation.
      req0 = 1; op0 = 32'h1234_5678; mode0 = 0;
      wait_ack(0, n);
      @(negedge clk);
      @(negedge clk);
      chk("slice2_ivalid", eng_ivalid, 1);
      chk("slice2_data", eng_data, 8'h56);
      rst_n = 1'b0;
      #1;
      check_all_zero("midfeed_reset");
      @(negedge clk);
      @(negedge clk); rst_n = 1'b1;
      for (int i = 0; i < 4; i++) @(negedge clk);
      chk("no_rsp_after_reset", rsp_valid, 0);

      // Pointer reset favours req0; engine over-range count is saturated;
      // then a TURBO op on requester 1 finishes after two slices.
      req0 = 1; op0 = 32'h0000_0000; mode0 = 0;
      req1 = 1; op1 = 32'h00FF_0000; mode1 = 1;
      push(0, sat(40), 0);
      push(1, sat(8), 0);
      wait_ack(0, n);
      feed(32'h0000_0000, 0, -1, 6'd40);
      wait_ack(1, n);
      feed(32'h00FF_0000, 1, 1, 6'd8);
      @(negedge clk);
      chk("turbo_done_ivalid", eng_ivalid, 0);

      // Silent engine.
      req0 = 1; op0 = 32'h0001_0000; mode0 = 0;
`ifdef LZC_ARB_TIMEOUT_EN
      push(0, 6'd32, 1);
`endif
      wait_ack(0, n);
      feed(32'h0001_0000, 0, -2, 6'd0);
      n = 1;
      while (!rsp_valid && n < 40) begin
         @(negedge clk);
         n++;
      end
`ifdef LZC_ARB_TIMEOUT_EN
      chk("timeout_cycles", n, 17);
      @(negedge clk);
`else
      chk("no_timeout_rsp", rsp_valid, 0);
      chk("still_waiting", eng_mode === 1'b0 && eng_ivalid === 1'b0, 1);
      rst_n = 1'b0;
      @(negedge clk); rst_n = 1'b1;
`endif
      @(negedge clk);

      chk("scoreboard_empty", sb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
